// File: rtl/fpu_pkg.sv
// Shared constants and state encoding for the FPU operand-alignment slice.
package fpu_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MAN_W     = 24;
  localparam int unsigned MAX_SHIFT = MAN_W + 2;
  localparam int unsigned GRS_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/unit_sel_exp.sv
// Combinational exponent compare: larger exponent, unsigned difference, swap flag.
module unit_sel_exp
  import fpu_pkg::*;
(
  input  logic [EXP_W-1:0] i_ExpA,
  input  logic [EXP_W-1:0] i_ExpB,
  output logic [EXP_W-1:0] o_Exp,
  output logic [EXP_W-1:0] o_E_sub,
  output logic             o_Ce_lt
);

  always_comb begin
    o_Ce_lt = (i_ExpA < i_ExpB);
    // Subtract the smaller from the larger so the 8-bit difference never wraps
    if (o_Ce_lt) begin
      o_Exp   = i_ExpB;
      o_E_sub = i_ExpB - i_ExpA;
    end else begin
      o_Exp   = i_ExpA;
      o_E_sub = i_ExpA - i_ExpB;
    end
  end

endmodule

// File: rtl/fpu_align_seq.sv
// Sequential significand alignment: compare exponents, then shift the smaller operand with sticky.
// Define FPU_ALIGN_SHIFT4_EN to shift up to 4 places per cycle instead of 1.
module fpu_align_seq #(
  parameter int unsigned MAN_W     = fpu_pkg::MAN_W,
  parameter int unsigned MAX_SHIFT = fpu_pkg::MAX_SHIFT
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [fpu_pkg::EXP_W-1:0]           i_ExpA,
  input  logic [fpu_pkg::EXP_W-1:0]           i_ExpB,
  input  logic [MAN_W-1:0]                    i_ManA,
  input  logic [MAN_W-1:0]                    i_ManB,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [fpu_pkg::EXP_W-1:0]           o_Exp,
  output logic [MAN_W-1:0]                    o_ManL,
  output logic [MAN_W+fpu_pkg::GRS_W-1:0]     o_ManS,
  output logic                                o_Ce_lt
);

  import fpu_pkg::*;

`ifdef FPU_ALIGN_SHIFT4_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif

  localparam int unsigned       MS_W        = MAN_W + GRS_W;
  localparam logic [4:0]        STEP_C      = 5'(STEP);
  localparam logic [EXP_W-1:0]  MAX_SHIFT_E = EXP_W'(MAX_SHIFT);

  state_e state_q, state_d;

  logic [EXP_W-1:0] exp_a_q, exp_b_q;
  logic [MAN_W-1:0] man_a_q, man_b_q;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W-1:0] man_l_q;
  logic [MS_W-1:0]  man_s_q;
  logic             ce_lt_q;
  logic [4:0]       cnt_q;

  logic [EXP_W-1:0] sel_exp, e_sub;
  logic             sel_lt;
  logic [4:0]       cnt_load;
  logic [4:0]       k;
  logic [4:0]       cnt_next;
  logic [MS_W-1:0]  shifted;
  logic [MS_W-1:0]  man_s_shift;
  logic             sticky;

  unit_sel_exp u_sel_exp (
    .i_ExpA  (exp_a_q),
    .i_ExpB  (exp_b_q),
    .o_Exp   (sel_exp),
    .o_E_sub (e_sub),
    .o_Ce_lt (sel_lt)
  );

  assign cnt_load = (e_sub > MAX_SHIFT_E) ? MAX_SHIFT_E[4:0] : e_sub[4:0];

  // Variable right shift by k <= STEP; every bit dropped off the bottom folds into bit 0
  always_comb begin
    k        = (cnt_q < STEP_C) ? cnt_q : STEP_C;
    cnt_next = cnt_q - k;
    shifted  = man_s_q >> k;
    sticky   = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (5'(i) < k) sticky = sticky | man_s_q[i];
    end
    man_s_shift = {shifted[MS_W-1:1], shifted[0] | sticky};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_valid) state_d = CMP;
      CMP:     state_d = (cnt_load == 5'd0) ? DONE : SHIFT;
      SHIFT:   if (cnt_next == 5'd0) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == IDLE);
    o_valid = (state_q == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      exp_a_q <= '0;
      exp_b_q <= '0;
      man_a_q <= '0;
      man_b_q <= '0;
      exp_q   <= '0;
      man_l_q <= '0;
      man_s_q <= '0;
      ce_lt_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            exp_a_q <= i_ExpA;
            exp_b_q <= i_ExpB;
            man_a_q <= i_ManA;
            man_b_q <= i_ManB;
          end
        end
        CMP: begin
          exp_q   <= sel_exp;
          ce_lt_q <= sel_lt;
          man_l_q <= sel_lt ? man_b_q : man_a_q;
          man_s_q <= {(sel_lt ? man_a_q : man_b_q), {GRS_W{1'b0}}};
          cnt_q   <= cnt_load;
        end
        SHIFT: begin
          man_s_q <= man_s_shift;
          cnt_q   <= cnt_next;
        end
        default: ;
      endcase
    end
  end

  assign o_Exp   = exp_q;
  assign o_ManL  = man_l_q;
  assign o_ManS  = man_s_q;
  assign o_Ce_lt = ce_lt_q;

endmodule

// File: doc/fpu_align_seq.md
FPU_ALIGN_SEQ -- requirements
Module: fpu_align_seq

Interface
REQ-001 SHALL have parameter MAN_W, default 24, meaning significand width including the hidden bit.
REQ-002 SHALL have parameter MAX_SHIFT, default 26 (MAN_W+2), meaning the clamp applied to the exponent difference.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1 bit: an operand pair is offered.
REQ-006 SHALL have port o_ready, output, 1 bit: the block accepts an operand pair.
REQ-007 SHALL have ports i_ExpA and i_ExpB, input, 8 bits each: biased exponents.
REQ-008 SHALL have ports i_ManA and i_ManB, input, MAN_W bits each: significands with the hidden bit.
REQ-009 SHALL have port o_valid, output, 1 bit: an aligned result is presented.
REQ-010 SHALL have port i_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 SHALL have port o_Exp, output, 8 bits: the common (larger) exponent.
REQ-012 SHALL have port o_ManL, output, MAN_W bits: the significand of the larger-exponent operand, unshifted.
REQ-013 SHALL have port o_ManS, output, MAN_W+3 bits: the aligned smaller-exponent significand as {mantissa, G, R, S}.
REQ-014 SHALL have port o_Ce_lt, output, 1 bit: set when ExpA < ExpB, i.e. the operands were swapped.

Function
REQ-015 SHALL implement four states:
- IDLE: o_ready=1.
- CMP: one cycle.
- SHIFT.
- DONE: o_valid=1.
o_ready SHALL be 0 in every state other than IDLE.
REQ-016 Accept: IDLE and i_valid=1 at an edge -> capture all operand inputs and go to CMP; i_valid in any other state is ignored.
REQ-017 CMP: register o_Exp=max(ExpA,ExpB), o_Ce_lt=(ExpA<ExpB), o_ManL=larger-exponent significand, o_ManS={smaller-exponent significand,3'b000}, and load the shift counter with min(|ExpA-ExpB|, MAX_SHIFT).
REQ-018 CMP: if the counter value is 0, go to DONE; otherwise go to SHIFT.
REQ-019 Tie ExpA==ExpB: treated as no swap; o_Ce_lt=0 and o_ManL=ManA.
REQ-020 SHIFT: each cycle, shift o_ManS right by k=min(STEP,counter), insert zeros at the MSB, OR all bits shifted out plus the old bit 0 into the new bit 0 (sticky), and decrement the counter by k.
REQ-021 SHIFT exit: go to DONE on the cycle the counter reaches 0.
REQ-022 STEP SHALL be 1, or 4 per REQ-029.
REQ-023 Latency: o_valid SHALL rise 2+ceil(min(E_sub,MAX_SHIFT)/STEP) edges after the accept edge.
REQ-024 DONE: o_Exp, o_ManL, o_ManS and o_Ce_lt SHALL be held stable while o_valid=1 and i_ready=0; on i_ready=1 at an edge, go to IDLE.
REQ-025 The counter SHALL be 5 bits wide, SHALL never underflow, and |ExpA-ExpB| SHALL be computed in unsigned 8-bit arithmetic with no wrap (range 0..255 before the clamp).

Reset
REQ-026 i_rst=1 at an edge SHALL force IDLE, o_valid=0, o_ready=1, and o_Exp, o_ManL, o_ManS, o_Ce_lt and the counter to 0, from any state including mid-SHIFT and DONE.
REQ-027 The block SHALL NOT accept an operand on an edge where i_rst=1.
REQ-028 The first accept SHALL be possible on the first edge with i_rst=0.

Configuration
REQ-029 Macro FPU_ALIGN_SHIFT4_EN:
- Defined: STEP=4; the last step shifts by the remainder.
- Undefined: STEP=1.
Results SHALL be bit-identical in both cases; only the latency differs.

Structure
REQ-030 Package fpu_pkg SHALL hold:
- the state enum (IDLE, CMP, SHIFT, DONE);
- EXP_W=8;
- MAN_W;
- MAX_SHIFT;
- the GRS width constant 3.
REQ-031 The exponent compare in CMP SHALL reuse the existing combinational sub-module unit_sel_exp (o_Exp, E_sub, Ce_lt); no other sub-module.

Verification
REQ-032 Equal exponents: ExpA=ExpB=0x80, ManA=0x800000, ManB=0xC00000 -> o_valid at accept+2; o_Exp=0x80, Ce_lt=0, ManL=0x800000, ManS=0x6000000.
REQ-033 Swap: ExpA=0x7E, ExpB=0x81, ManA=0x800000, ManB=0xA00000 -> Ce_lt=1, o_Exp=0x81, ManL=0xA00000, ManS=0x0800000; o_valid at accept+5 (STEP=1) or accept+3 (STEP=4).
REQ-034 Clamp: ExpA=0xFF, ExpB=0x00, ManB=0x800001 -> shift of 26 applied; ManS=0x0000001 (sticky only); o_valid at accept+28 (STEP=1) or accept+9 (STEP=4).
REQ-035 Backpressure: i_ready=0 for 5 cycles in DONE with i_valid=1 held -> outputs constant, o_ready=0, no new accept; i_ready=1 -> IDLE next edge.
REQ-036 Reset mid-SHIFT: i_rst pulsed 1 cycle during the REQ-034 run -> next edge o_valid=0, o_ready=1, all data outputs 0; a following REQ-032 transaction completes correctly.
